// File: rtl/boruss_cpu_fetch_unit.sv
// Instruction prefetch unit: fetches bytes ahead of execution over a req/ack
// memory port and queues them with their address for the control FSM.
module boruss_cpu_fetch_unit #(
  parameter int unsigned DEPTH       = 4,
  parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic       instruction_valid,
  output logic [7:0] instruction_data,
  output logic [7:0] instruction_pc,
  input  logic       instruction_pop,
  input  logic       flush,
  input  logic [7:0] flush_addr,
  output logic       halt_fetched
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] pc;
  } entry_t;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD, STOP} state_t;

  state_t        state;
  entry_t        fifo [DEPTH];
  logic [CW-1:0] count;
  logic          valid_q;
  logic [7:0]    fetch_ptr;
  logic [7:0]    flush_addr_q;

  logic          pop_c;
  logic          push_c;
  logic          room_c;
  logic [CW-1:0] count_next_c;
  logic [AW-1:0] wr_idx_c;
  logic [7:0]    addr_inc_c;

  // Occupancy after this cycle's push/pop decides whether another request fits.
  always_comb begin
    pop_c        = instruction_pop & valid_q & ~flush;
    push_c       = (state == REQ) & mem_ack & ~flush;
    count_next_c = count + CW'(push_c) - CW'(pop_c);
    room_c       = count_next_c < CW'(DEPTH);
    wr_idx_c     = AW'(count - CW'(pop_c));
    addr_inc_c   = mem_addr + 8'd1;
  end

  // Shift FIFO: entry 0 is always the head, so head outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      valid_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else if (flush) begin
      count   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (pop_c) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) fifo[i] <= fifo[i+1];
      end
      if (push_c) fifo[wr_idx_c] <= entry_t'({mem_rdata, mem_addr});
      count   <= count_next_c;
      valid_q <= (count_next_c != '0);
    end
  end

  assign instruction_valid = valid_q;
  assign instruction_data  = fifo[0].data;
  assign instruction_pc    = fifo[0].pc;

  // Request FSM; a flush during an outstanding request waits out its ack in DISCARD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mem_req      <= 1'b0;
      mem_addr     <= 8'h00;
      fetch_ptr    <= 8'h00;
      flush_addr_q <= 8'h00;
      halt_fetched <= 1'b0;
    end else begin
      if (flush) halt_fetched <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            state     <= REQ;
            mem_req   <= 1'b1;
            mem_addr  <= flush_addr;
            fetch_ptr <= flush_addr;
          end else if (room_c && !halt_fetched) begin
            state    <= REQ;
            mem_req  <= 1'b1;
            mem_addr <= fetch_ptr;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (flush) begin
              mem_addr  <= flush_addr;
              fetch_ptr <= flush_addr;
            end else begin
              fetch_ptr <= addr_inc_c;
              if (mem_rdata == HALT_OPCODE) begin
                state        <= STOP;
                mem_req      <= 1'b0;
                halt_fetched <= 1'b1;
              end else if (room_c) begin
                mem_addr <= addr_inc_c;
              end else begin
                state   <= IDLE;
                mem_req <= 1'b0;
              end
            end
          end else if (flush) begin
            state        <= DISCARD;
            flush_addr_q <= flush_addr;
          end
        end
        DISCARD: begin
          if (mem_ack) begin
            state     <= REQ;
            mem_addr  <= flush ? flush_addr : flush_addr_q;
            fetch_ptr <= flush ? flush_addr : flush_addr_q;
          end else if (flush) begin
            flush_addr_q <= flush_addr;
          end
        end
        STOP: begin
          if (flush) begin
            state     <= REQ;
            mem_req   <= 1'b1;
            mem_addr  <= flush_addr;
            fetch_ptr <= flush_addr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boruss_cpu_fetch_unit.sv
// Bench for boruss_cpu_fetch_unit: directed scenarios plus a random phase,
// checked every cycle against a queue-based model of the fetched stream.
module tb_boruss_cpu_fetch_unit;

  localparam int unsigned DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       instruction_valid;
  logic [7:0] instruction_data;
  logic [7:0] instruction_pc;
  logic       instruction_pop;
  logic       flush;
  logic [7:0] flush_addr;
  logic       halt_fetched;

  boruss_cpu_fetch_unit #(.DEPTH(DEPTH), .HALT_OPCODE(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instruction_valid(instruction_valid), .instruction_data(instruction_data),
    .instruction_pc(instruction_pc), .instruction_pop(instruction_pop),
    .flush(flush), .flush_addr(flush_addr), .halt_fetched(halt_fetched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] pc;
  } ent_t;

  int   vectors;
  int   miscompares;
  logic [7:0] mem [256];

  // Memory responder state
  int   lat;
  int   lat_cur;
  int   age;
  bit   rand_lat;
  bit   stray;

  // Reference model of the instruction stream
  ent_t       q[$];
  bit         halted;
  bit         discard;
  logic [7:0] exp_addr;
  bit         was_reset;
  bit         hold;
  logic [7:0] hold_addr;
  int         delivered;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_mem();
    if (mem_req) begin
      if (age == 0) lat_cur = rand_lat ? int'($urandom_range(0, 3)) : lat;
      if (age >= lat_cur) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        age       = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        age++;
      end
    end else begin
      age       = 0;
      mem_ack   = stray && ($urandom_range(0, 3) == 0);
      mem_rdata = 8'($urandom);
    end
  endtask

  task automatic check_outputs();
    if (was_reset) begin
      chk("rst_req", 8'(mem_req), 8'h00);
      chk("rst_addr", mem_addr, 8'h00);
      chk("rst_valid", 8'(instruction_valid), 8'h00);
      chk("rst_data", instruction_data, 8'h00);
      chk("rst_pc", instruction_pc, 8'h00);
      chk("rst_halt", 8'(halt_fetched), 8'h00);
    end else begin
      chk("valid", 8'(instruction_valid), 8'(q.size() != 0));
      if (q.size() != 0) begin
        chk("head_data", instruction_data, q[0].data);
        chk("head_pc", instruction_pc, q[0].pc);
      end
      chk("halt", 8'(halt_fetched), 8'(halted));
      chk("req", 8'(mem_req), 8'(!halted && q.size() < DEPTH));
      if (mem_req && !discard) chk("req_addr", mem_addr, exp_addr);
      if (hold) chk("addr_stable", mem_addr, hold_addr);
    end
  endtask

  // One clock: respond as memory, advance the model with this cycle's inputs, check.
  task automatic step();
    logic       c_req, c_ack, c_flush, c_pop, c_rst;
    logic [7:0] c_addr, c_rd, c_faddr;
    drive_mem();
    c_req = mem_req; c_addr = mem_addr; c_ack = mem_ack; c_rd = mem_rdata;
    c_flush = flush; c_faddr = flush_addr; c_pop = instruction_pop; c_rst = reset;
    @(posedge clk);
    #1;
    hold = 1'b0;
    if (c_rst) begin
      q.delete();
      halted = 1'b0; discard = 1'b0; exp_addr = 8'h00; was_reset = 1'b1;
    end else begin
      was_reset = 1'b0;
      hold      = c_req && !c_ack;
      hold_addr = c_addr;
      if (c_flush) begin
        q.delete();
        halted   = 1'b0;
        exp_addr = c_faddr;
        discard  = c_req && !c_ack;
      end else begin
        if (c_pop && q.size() != 0) begin
          void'(q.pop_front());
          delivered++;
        end
        if (c_req && c_ack) begin
          if (discard) discard = 1'b0;
          else begin
            q.push_back('{data: c_rd, pc: c_addr});
            exp_addr = exp_addr + 8'd1;
            if (c_rd == 8'hFF) halted = 1'b1;
          end
        end
      end
    end
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int guard;
    vectors = 0; miscompares = 0;
    lat = 0; lat_cur = 0; age = 0; rand_lat = 1'b0; stray = 1'b0;
    halted = 1'b0; discard = 1'b0; exp_addr = 8'h00; was_reset = 1'b0;
    hold = 1'b0; hold_addr = 8'h00; delivered = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(8'h10 + 8'h11 * i);
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h00;
    instruction_pop = 1'b0; flush = 1'b0; flush_addr = 8'h00;

    // Reset, then zero-latency memory with no pops fills the FIFO
    run(2);
    reset = 1'b0;
    run(8);
    chk("t1_head_data", instruction_data, 8'h10);
    chk("t1_head_pc", instruction_pc, 8'h00);
    chk("t1_req_low", 8'(mem_req), 8'h00);

    // 3-cycle latency with a pop every cycle
    lat = 3;
    instruction_pop = 1'b1;
    guard = 0;
    while (delivered < 20 && guard < 400) begin step(); guard++; end
    chk("t2_delivered", 8'(delivered >= 20), 8'h01);
    instruction_pop = 1'b0;

    // Flush to 0x40 while a request is pending; its 0xAA reply must be dropped
    guard = 0;
    while (!(mem_req && age == 1) && guard < 50) begin step(); guard++; end
    chk("t3_pending", 8'(mem_req), 8'h01);
    mem[mem_addr] = 8'hAA;
    mem[8'h40] = 8'h5A;
    flush = 1'b1; flush_addr = 8'h40;
    step();
    flush = 1'b0;
    guard = 0;
    while (q.size() == 0 && guard < 30) begin step(); guard++; end
    chk("t3_pc", instruction_pc, 8'h40);
    chk("t3_data", instruction_data, 8'h5A);

    // Address wrap from 0xFE through 0x00
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
    lat = 0;
    flush = 1'b1; flush_addr = 8'hFE;
    step();
    flush = 1'b0;
    run(3);
    chk("t4_pc0", instruction_pc, 8'hFE);
    instruction_pop = 1'b1;
    step();
    chk("t4_pc1", instruction_pc, 8'hFF);
    step();
    chk("t4_pc2", instruction_pc, 8'h00);
    chk("t4_data2", instruction_data, 8'h33);
    instruction_pop = 1'b0;

    // HALT byte at 0x03 stops prefetch; flush resumes
    mem[8'h00] = 8'h01; mem[8'h01] = 8'h02; mem[8'h02] = 8'h03; mem[8'h03] = 8'hFF;
    lat = 1;
    flush = 1'b1; flush_addr = 8'h00;
    step();
    flush = 1'b0;
    run(12);
    chk("t5_halt", 8'(halt_fetched), 8'h01);
    chk("t5_noreq", 8'(mem_req), 8'h00);
    instruction_pop = 1'b1;
    run(6);
    chk("t5_drained", 8'(instruction_valid), 8'h00);
    instruction_pop = 1'b0;
    mem[8'h03] = 8'h44;
    flush = 1'b1; flush_addr = 8'h00;
    step();
    flush = 1'b0;
    chk("t5_halt_clr", 8'(halt_fetched), 8'h00);
    run(10);
    chk("t5_resumed", 8'(q.size() == DEPTH), 8'h01);

    // Reset mid-request with two entries buffered
    lat = 3;
    flush = 1'b1; flush_addr = 8'h00;
    step();
    flush = 1'b0;
    guard = 0;
    while (!(q.size() == 2 && mem_req) && guard < 40) begin step(); guard++; end
    chk("t6_setup", 8'(q.size()), 8'h02);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("t6_restart_req", 8'(mem_req), 8'h01);
    chk("t6_restart_addr", mem_addr, 8'h00);

    // Random traffic: variable latency, stray acks, pops, flushes, resets, HALTs
    rand_lat = 1'b1;
    stray = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 254));
    for (int i = 0; i < 4; i++) mem[8'($urandom)] = 8'hFF;
    for (int i = 0; i < 2500; i++) begin
      instruction_pop = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 24) == 0);
      flush_addr = 8'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; flush = 1'b0; instruction_pop = 1'b0;
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/boruss_cpu_fetch_unit.md
# boruss_cpu_fetch_unit

Instruction prefetch unit between 8-bit program memory and the CPU control FSM. It fetches instruction bytes ahead of execution over a req/ack memory handshake with variable latency, and buffers them in a DEPTH-entry FIFO tagged with their address. It presents the oldest byte to the FSM. It flushes and restarts from a new address when a jump is taken, and stops prefetching after fetching HALT (0xFF).

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..8
- HALT_OPCODE, 8'hFF, byte that stops prefetch
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- mem_req  out  1  memory request, registered
- mem_addr  out  8  request address, registered, stable while mem_req high
- mem_ack  in  1  request complete; mem_rdata valid this cycle
- mem_rdata  in  8  instruction byte
- instruction_valid  out  1  FIFO head valid
- instruction_data  out  8  FIFO head byte
- instruction_pc  out  8  address of FIFO head byte
- instruction_pop  in  1  consume head; ignored when instruction_valid=0
- flush  in  1  jump taken: discard FIFO, restart at flush_addr
- flush_addr  in  8  new fetch address
- halt_fetched  out  1  HALT_OPCODE pushed; prefetch stopped

## Operation
- Reset values: mem_req=0, mem_addr=0x00, instruction_valid=0, instruction_data=0x00, instruction_pc=0x00, halt_fetched=0, FIFO count=0, fetch pointer=0x00.
- Request FSM states are IDLE, REQ, DISCARD and STOP.
- IDLE -> REQ when the FIFO has room (count < DEPTH, counting the current cycle's push/pop) and halt_fetched=0. Set mem_req=1 and mem_addr=fetch pointer.
- REQ: hold mem_req and mem_addr until mem_ack.
  - On ack: push {mem_rdata, mem_addr} and increment the fetch pointer mod 256 (0xFF wraps to 0x00).
  - If rdata==HALT_OPCODE, go to STOP and set halt_fetched=1.
  - Otherwise stay in REQ with the next address if room remains after the push; else go to IDLE.
- REQ with flush and no ack: go to DISCARD. mem_req stays high on the old address until ack, and the returned data is dropped. Then load the fetch pointer from the latched flush_addr and issue the next request.
- flush in any state clears the FIFO (count=0, instruction_valid=0) and clears halt_fetched.
  - Next fetch address = flush_addr.
  - From IDLE or STOP, go to REQ.
- flush together with mem_ack in the same cycle: the ack completes the old request and its data is dropped. The request to flush_addr issues in the next cycle.
- flush together with instruction_pop: the pop is ignored.
- A second flush while in DISCARD overwrites the latched flush_addr.
- STOP: no requests. Leave STOP only on flush or reset. The FIFO still drains via pop.
- Push and pop in the same cycle: count is unchanged. When the FIFO is full, the fetch unit keeps mem_req low.
- mem_ack while mem_req=0 is ignored.
- reset during an outstanding request: mem_req drops the next cycle. The memory must tolerate the abandoned request.

## Timing
- First mem_req=1 (addr 0x00) in the first cycle after reset is sampled low.
- Ack in cycle N with an empty FIFO: instruction_valid=1 with that byte in N+1 (registered head).
- Back-to-back: ack in N -> mem_req stays high with addr+1 in N+1, so a zero-latency memory gives 1 byte per cycle.
- pop in N: the next entry (or valid=0) appears in N+1.
- flush in N: instruction_valid=0 in N+1.
  - With no request outstanding, mem_req=1 at flush_addr in N+1.
  - With a request outstanding, mem_req=1 at flush_addr in the cycle after its ack.
- halt_fetched rises in the cycle after the HALT byte's ack.

## Test plan
- Memory with fixed 0-cycle ack, contents 0x10,0x21,0x32…; no pops -> addresses 0x00..0x03 fetched back-to-back, mem_req low after DEPTH=4 pushes, head=0x10 with pc=0x00.
- Memory with 3-cycle ack latency, pop every cycle valid=1 -> bytes delivered in address order with correct pc tags, no duplicates or losses over 20 bytes.
- Flush to 0x40 while a request to 0x05 is pending, ack 2 cycles later with 0xAA -> 0xAA never appears, next mem_addr=0x40, FIFO empty in between.
- flush_addr=0xFE with memory 0xFE=0x11, 0xFF=0x22, 0x00=0x33 -> pc tags 0xFE, 0xFF, 0x00 (wrap).
- Byte 0xFF at address 0x03 -> halt_fetched=1, no request to 0x04; FIFO drains to valid=0; flush to 0x00 clears halt_fetched and fetching resumes.
- reset asserted mid-request with the FIFO holding 2 entries -> next cycle mem_req=0, valid=0, all outputs at reset values; after release, fetch restarts at 0x00.
